// File: rtl/set_input_ctrl_pkg.sv
// Shared edit-mode encoding, one-hot select decode and sizing helpers for the
// front-panel set/adjust logic and its consumers (counter chain, display blink).
package set_input_ctrl_pkg;

  localparam logic [2:0] MODE_RUN   = 3'd0;
  localparam logic [2:0] MODE_SEC   = 3'd1;
  localparam logic [2:0] MODE_MIN   = 3'd2;
  localparam logic [2:0] MODE_HOUR  = 3'd3;
  localparam logic [2:0] MODE_DAY   = 3'd4;
  localparam logic [2:0] MODE_MONTH = 3'd5;
  localparam logic [2:0] MODE_YEAR  = 3'd6;

  // Request handshake: IDLE until an accepted up/down press, HOLD until one
  // post-blanking 1 Hz edge plus one margin cycle has passed.
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_HOLD = 1'b1
  } req_state_t;

  typedef struct packed {
    logic year;
    logic month;
    logic day;
    logic hour;
    logic min;
    logic sec;
  } set_sel_t;

  function automatic set_sel_t decode_mode(input logic [2:0] mode);
    set_sel_t sel;
    sel = '0;
    case (mode)
      MODE_SEC:   sel.sec   = 1'b1;
      MODE_MIN:   sel.min   = 1'b1;
      MODE_HOUR:  sel.hour  = 1'b1;
      MODE_DAY:   sel.day   = 1'b1;
      MODE_MONTH: sel.month = 1'b1;
      MODE_YEAR:  sel.year  = 1'b1;
      default:    sel       = '0;
    endcase
    return sel;
  endfunction

  function automatic logic [2:0] next_mode(input logic [2:0] mode);
    return (mode >= MODE_YEAR) ? MODE_RUN : mode + 3'd1;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/set_input_ctrl_btn_debounce.sv
// One push-button input path: 2-FF synchronizer, polarity normalisation,
// stability counter and a single-cycle pulse on each accepted press.
module btn_debounce
  import set_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          sample;

  assign sample = sync[1] ^ BTN_ACTIVE_LOW;

  // The synchronizer resets to the released raw level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= {2{BTN_ACTIVE_LOW}};
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sample;
        press <= sample;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/set_input_ctrl.sv
// Front-panel controller: debounced keys step the edit mode and issue inc/dec
// requests held until exactly one post-blanking clk_1hz rising edge.
module set_input_ctrl
  import set_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int BLANK_CYCLES    = 3
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       btn_mode_raw,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       clk_1hz,
  output logic       set_sec,
  output logic       set_min,
  output logic       set_hour,
  output logic       set_day,
  output logic       set_month,
  output logic       set_year,
  output logic       inc,
  output logic       dec,
  output logic       busy,
  output logic [2:0] edit_mode
);

  localparam int TW = count_width(TIMEOUT_CYCLES + 1);
  localparam int BW = count_width(BLANK_CYCLES + 1);
  localparam logic [TW-1:0] TO_VAL    = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BLANK_VAL = BW'(BLANK_CYCLES);

  logic mode_press;
  logic up_press;
  logic down_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_db_mode (
    .clk  (clk_50MHz),
    .rst  (rst),
    .raw  (btn_mode_raw),
    .press(mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_db_up (
    .clk  (clk_50MHz),
    .rst  (rst),
    .raw  (btn_up_raw),
    .press(up_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_db_down (
    .clk  (clk_50MHz),
    .rst  (rst),
    .raw  (btn_down_raw),
    .press(down_press)
  );

  logic [1:0]    hz_sync;
  logic          hz_prev;
  logic          hz_edge;
  req_state_t    req_state;
  logic          margin;
  logic [BW-1:0] blank_cnt;
  logic [TW-1:0] timer;
  set_sel_t      set_sel;
  logic          mode_go;
  logic          req_go;
  logic          timeout_hit;
  logic [2:0]    mode_nxt;

  assign hz_edge = hz_sync[1] & ~hz_prev;

  // A mode press in the same cycle as up/down takes precedence; up+down together cancel.
  assign mode_go = mode_press & ~busy;
  assign req_go  = ~busy & ~mode_press & (up_press ^ down_press) & (edit_mode != MODE_RUN);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (edit_mode != MODE_RUN) && !busy &&
                       !req_go && (timer == TO_VAL);

  always_comb begin
    mode_nxt = edit_mode;
    if (mode_go) begin
      mode_nxt = next_mode(edit_mode);
    end else if (timeout_hit) begin
      mode_nxt = MODE_RUN;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      hz_sync   <= 2'b00;
      hz_prev   <= 1'b0;
      edit_mode <= MODE_RUN;
      set_sel   <= '0;
      timer     <= '0;
      req_state <= REQ_IDLE;
      margin    <= 1'b0;
      blank_cnt <= '0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      hz_sync   <= {hz_sync[0], clk_1hz};
      hz_prev   <= hz_sync[1];
      edit_mode <= mode_nxt;
      set_sel   <= decode_mode(mode_nxt);

      if (mode_go || req_go || mode_nxt == MODE_RUN) begin
        timer <= '0;
      end else if (edit_mode != MODE_RUN && !busy && timer != TO_VAL) begin
        timer <= timer + 1'b1;
      end

      case (req_state)
        REQ_IDLE: begin
          if (req_go) begin
            req_state <= REQ_HOLD;
            inc       <= up_press;
            dec       <= down_press;
            busy      <= 1'b1;
            blank_cnt <= '0;
            margin    <= 1'b0;
          end
        end
        REQ_HOLD: begin
          // Edges in the first BLANK_CYCLES may predate the request reaching the 1 Hz domain.
          if (margin) begin
            req_state <= REQ_IDLE;
            margin    <= 1'b0;
            inc       <= 1'b0;
            dec       <= 1'b0;
            busy      <= 1'b0;
          end else if (hz_edge && blank_cnt >= BLANK_VAL) begin
            margin <= 1'b1;
          end else if (blank_cnt != BLANK_VAL) begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: begin
          req_state <= REQ_IDLE;
          inc       <= 1'b0;
          dec       <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign set_sec   = set_sel.sec;
  assign set_min   = set_sel.min;
  assign set_hour  = set_sel.hour;
  assign set_day   = set_sel.day;
  assign set_month = set_sel.month;
  assign set_year  = set_sel.year;

endmodule
